// File: rtl/ota_bitstream_decimator.sv
`default_nettype none
// ============================================================================
// ota_bitstream_decimator
// Synchronises/debounces the OTA comparator bit and reports per-window counts.
// Revision: 1.0
// ============================================================================
module ota_bitstream_decimator #(
   parameter int WINDOW_LOG2 = 8,
   parameter int FILT_LEN    = 3,
   parameter int SETTLE_CYC  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   cmp_in,
   input  logic                   result_ready,
   input  logic                   clear_ovr,
   output logic                   result_valid,
   output logic [WINDOW_LOG2:0]   ones_count,
   output logic [WINDOW_LOG2:0]   edge_count,
   output logic                   overrun,
   output logic                   cmp_filt,
   output logic                   busy
);

   localparam int CW  = WINDOW_LOG2 + 1;
   localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [FCW-1:0]         FILT_LAST   = FCW'(FILT_LEN - 1);
   localparam logic [SCW-1:0]         SETTLE_LAST = SCW'(SETTLE_CYC - 1);
   localparam logic [WINDOW_LOG2-1:0] WIN_LAST    = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ACCUM  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   s1_q, s2_q;
   logic [FCW-1:0]         fcnt_q;
   logic                   filt_q, filt_prev_q;
   logic [SCW-1:0]         scnt_q, scnt_d;
   logic [WINDOW_LOG2-1:0] wcnt_q, wcnt_d;
   logic [CW-1:0]          ones_q, ones_d;
   logic [CW-1:0]          edges_q, edges_d;
   logic                   valid_q, valid_d;
   logic [CW-1:0]          ones_out_q, ones_out_d;
   logic [CW-1:0]          edges_out_q, edges_out_d;
   logic                   ovr_q, ovr_d;
   logic                   win_end;
   logic                   load;
   logic                   drop;
   logic [CW-1:0]          win_ones;
   logic [CW-1:0]          win_edges;

   // Synchroniser and debounce filter run every cycle, independent of the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         fcnt_q      <= '0;
         filt_q      <= 1'b0;
         filt_prev_q <= 1'b0;
      end else begin
         s1_q        <= cmp_in;
         s2_q        <= s1_q;
         filt_prev_q <= filt_q;
         if (s2_q == filt_q) begin
            fcnt_q <= '0;
         end else if (fcnt_q == FILT_LAST) begin
            filt_q <= s2_q;
            fcnt_q <= '0;
         end else begin
            fcnt_q <= fcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         scnt_q      <= '0;
         wcnt_q      <= '0;
         ones_q      <= '0;
         edges_q     <= '0;
         valid_q     <= 1'b0;
         ones_out_q  <= '0;
         edges_out_q <= '0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         scnt_q      <= scnt_d;
         wcnt_q      <= wcnt_d;
         ones_q      <= ones_d;
         edges_q     <= edges_d;
         valid_q     <= valid_d;
         ones_out_q  <= ones_out_d;
         edges_out_q <= edges_out_d;
         ovr_q       <= ovr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      scnt_d    = scnt_q;
      wcnt_d    = wcnt_q;
      ones_d    = ones_q;
      edges_d   = edges_q;
      win_end   = 1'b0;
      // Window totals include the current cycle's contribution.
      win_ones  = ones_q + CW'(filt_q);
      win_edges = edges_q + CW'(filt_q ^ filt_prev_q);

      case (state_q)
         ST_IDLE: begin
            scnt_d  = '0;
            wcnt_d  = '0;
            ones_d  = '0;
            edges_d = '0;
            if (en) begin
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (scnt_q == SETTLE_LAST) begin
               state_d = ST_ACCUM;
               scnt_d  = '0;
               wcnt_d  = '0;
            end else begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         ST_ACCUM: begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == WIN_LAST) begin
               win_end = 1'b1;
               ones_d  = '0;
               edges_d = '0;
            end else begin
               ones_d  = win_ones;
               edges_d = win_edges;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Dropping en abandons the partial window without emitting anything.
      if (!en && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         scnt_d  = '0;
         wcnt_d  = '0;
         ones_d  = '0;
         edges_d = '0;
         win_end = 1'b0;
      end
   end

   always_comb begin
      load        = win_end && (!valid_q || result_ready);
      drop        = win_end && valid_q && !result_ready;
      valid_d     = valid_q;
      ones_out_d  = ones_out_q;
      edges_out_d = edges_out_q;
      if (load) begin
         valid_d     = 1'b1;
         ones_out_d  = win_ones;
         edges_out_d = win_edges;
      end else if (valid_q && result_ready) begin
         valid_d = 1'b0;
      end
      if (drop) begin
         ovr_d = 1'b1;
      end else if (clear_ovr) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   assign result_valid = valid_q;
   assign ones_count   = ones_out_q;
   assign edge_count   = edges_out_q;
   assign overrun      = ovr_q;
   assign cmp_filt     = filt_q;
   assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ota_bitstream_decimator.sv
`default_nettype none
// Scoreboard bench for ota_bitstream_decimator: 16-cycle windows, FILT_LEN=2, SETTLE_CYC=4.
module tb_ota_bitstream_decimator;

   localparam int WL = 4;
   localparam int FL = 2;
   localparam int SC = 4;
   localparam int CW = WL + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          cmp_in;
   logic          result_ready;
   logic          clear_ovr;
   logic          result_valid;
   logic [CW-1:0] ones_count;
   logic [CW-1:0] edge_count;
   logic          overrun;
   logic          cmp_filt;
   logic          busy;

   logic [2*CW-1:0] exp_q[$];
   logic [2*CW-1:0] exp_w;
   int n_chk  = 0;
   int n_pass = 0;
   int sq_ph  = 0;
   int vcnt;

   ota_bitstream_decimator #(
      .WINDOW_LOG2 (WL),
      .FILT_LEN    (FL),
      .SETTLE_CYC  (SC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .cmp_in       (cmp_in),
      .result_ready (result_ready),
      .clear_ovr    (clear_ovr),
      .result_valid (result_valid),
      .ones_count   (ones_count),
      .edge_count   (edge_count),
      .overrun      (overrun),
      .cmp_filt     (cmp_filt),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Square wave, 4 cycles high / 4 cycles low.
   task automatic sq(input int n);
      for (int i = 0; i < n; i++) begin
         cmp_in = sq_ph[2];
         sq_ph++;
         tick(1);
      end
   endtask

   task automatic push_exp(input int ones, input int edges);
      exp_q.push_back({CW'(ones), CW'(edges)});
   endtask

   // A handshake will complete on the coming edge: compare against the oldest expectation.
   always @(negedge clk) begin
      #1;
      if (!rst && result_valid && result_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_unexpected", exp_q.size(), 1);
         end else begin
            exp_w = exp_q.pop_front();
            check_eq("sb_ones", ones_count, exp_w[2*CW-1:CW]);
            check_eq("sb_edges", edge_count, exp_w[CW-1:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; en = 1'b0; cmp_in = 1'b0; result_ready = 1'b0; clear_ovr = 1'b0;
      tick(3);
      check_eq("rst_valid", result_valid, 0);
      check_eq("rst_ones", ones_count, 0);
      check_eq("rst_edges", edge_count, 0);
      check_eq("rst_ovr", overrun, 0);
      check_eq("rst_filt", cmp_filt, 0);
      check_eq("rst_busy", busy, 0);
      rst = 1'b0;
      tick(2);

      // Filter latency 2+FILT_LEN, then a constant-high window.
      cmp_in = 1'b1;
      tick(3);
      check_eq("filt_lat_early", cmp_filt, 0);
      tick(1);
      check_eq("filt_lat", cmp_filt, 1);
      tick(2);
      en = 1'b1; result_ready = 1'b1;
      push_exp(16, 0);
      tick(1);
      check_eq("busy_after_en", busy, 1);
      tick(19);
      check_eq("valid_early", result_valid, 0);
      tick(1);
      check_eq("valid_first", result_valid, 1);
      check_eq("ones_first", ones_count, 16);
      tick(1);
      check_eq("valid_accepted", result_valid, 0);

      // Reset in the middle of ACCUM.
      tick(3);
      rst = 1'b1; en = 1'b0;
      tick(1);
      check_eq("mid_rst_valid", result_valid, 0);
      check_eq("mid_rst_ones", ones_count, 0);
      check_eq("mid_rst_filt", cmp_filt, 0);
      check_eq("mid_rst_busy", busy, 0);
      rst = 1'b0;
      tick(6);

      // 1-cycle glitch rejected, then a 3-cycle low pulse passes.
      en = 1'b1;
      push_exp(16, 0);
      tick(8);
      cmp_in = 1'b0;
      tick(1);
      cmp_in = 1'b1;
      tick(2);
      check_eq("glitch_filt", cmp_filt, 1);
      tick(10);
      check_eq("glitch_valid", result_valid, 1);
      push_exp(13, 2);
      cmp_in = 1'b0;
      tick(3);
      check_eq("pulse_filt_hold", cmp_filt, 1);
      cmp_in = 1'b1;
      tick(1);
      check_eq("pulse_filt_drop", cmp_filt, 0);
      tick(12);
      check_eq("pulse_valid", result_valid, 1);
      en = 1'b0;
      tick(1);

      // Steady-state square wave: three windows of 8 ones / 4 edges.
      sq(16);
      en = 1'b1;
      push_exp(8, 4); push_exp(8, 4); push_exp(8, 4);
      sq(21);
      check_eq("sq_valid", result_valid, 1);
      vcnt = 0;
      for (int i = 0; i < 32; i++) begin
         sq(1);
         vcnt += int'(result_valid);
      end
      check_eq("sq_valid_pulses", vcnt, 2);
      en = 1'b0;
      tick(1);

      // Overrun: ready low across two window ends.
      cmp_in = 1'b1;
      tick(6);
      result_ready = 1'b0; en = 1'b1;
      push_exp(16, 0);
      tick(36);
      check_eq("ovr_before", overrun, 0);
      check_eq("ovr_held_valid", result_valid, 1);
      tick(1);
      check_eq("ovr_set", overrun, 1);
      check_eq("ovr_held_ones", ones_count, 16);
      check_eq("ovr_held_edges", edge_count, 0);
      result_ready = 1'b1; en = 1'b0;
      tick(1);
      check_eq("ovr_accept_valid", result_valid, 0);
      check_eq("ovr_sticky", overrun, 1);
      clear_ovr = 1'b1;
      tick(1);
      check_eq("ovr_cleared", overrun, 0);
      clear_ovr = 1'b0;

      // Abort at window cycle 7, then a fresh window with cmp low.
      en = 1'b1;
      tick(12);
      check_eq("abort_busy_before", busy, 1);
      en = 1'b0;
      tick(1);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_valid", result_valid, 0);
      cmp_in = 1'b0;
      tick(6);
      check_eq("abort_valid_later", result_valid, 0);
      check_eq("abort_filt", cmp_filt, 0);
      en = 1'b1;
      push_exp(0, 0);
      tick(20);
      check_eq("fresh_valid_early", result_valid, 0);
      tick(1);
      check_eq("fresh_valid", result_valid, 1);
      en = 1'b0;
      tick(2);

      check_eq("sb_drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
